// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, mode constants,
// byte width and the shift helpers used by the datapath.
package spi_pkg;

  localparam int SPI_BITS       = 8;
  localparam int SPI_EDGES      = 2 * SPI_BITS;
  localparam int SPI_BIT_CNT_W  = $clog2(SPI_BITS);

  // {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } spi_state_e;

  function automatic logic [SPI_BITS-1:0] shl1(input logic [SPI_BITS-1:0] v);
    return {v[SPI_BITS-2:0], 1'b0};
  endfunction

  function automatic logic [SPI_BITS-1:0] shift_in(input logic [SPI_BITS-1:0] v,
                                                   input logic                b);
    return {v[SPI_BITS-2:0], b};
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: divides clk by CLK_DIV per half-period, emits 16 edges and
// then one extra silent tick (last_edge) that closes the hold half-period.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic cpol,
  output logic sclk,
  output logic lead_tick,
  output logic trail_tick,
  output logic last_edge
);

  localparam int              CW       = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0]   DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [4:0]      EDGE_END = 5'(SPI_EDGES);

  logic [CW-1:0] r_div;
  logic [4:0]    r_edge;
  logic          r_sclk;
  logic          w_tick;
  logic          w_in_burst;

  assign w_tick     = run && (r_div == DIV_LAST);
  assign w_in_burst = (r_edge < EDGE_END);

  // Divider, edge counter and the SCLK register; idle level tracks cpol
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div  <= '0;
      r_edge <= '0;
      r_sclk <= 1'b0;
    end else if (!run) begin
      r_div  <= '0;
      r_edge <= '0;
      r_sclk <= cpol;
    end else begin
      if (w_tick) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + CW'(1);
      end
      if (w_tick && w_in_burst) begin
        r_sclk <= ~r_sclk;
        r_edge <= r_edge + 5'd1;
      end else begin
        r_sclk <= r_sclk;
        r_edge <= r_edge;
      end
    end
  end

  // Edge k = r_edge+1, so even counts precede a leading (odd) edge
  assign lead_tick  = w_tick && w_in_burst && !r_edge[0];
  assign trail_tick = w_tick && w_in_burst &&  r_edge[0];
  assign last_edge  = w_tick && !w_in_burst;
  assign sclk       = r_sclk;

endmodule

// File: rtl/master_spi.sv
// Single-byte SPI master supporting all four CPOL/CPHA modes; owns the
// transfer FSM, the tx/rx shift registers and all registered outputs.
module master_spi
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpol,
  input  logic                cpha,
  input  logic                start,
  input  logic [SPI_BITS-1:0] data_in,
  input  logic                miso,
  output logic                sclk,
  output logic                mosi,
  output logic                ss,
  output logic                busy,
  output logic                done,
  output logic [SPI_BITS-1:0] data_out
);

  localparam logic [SPI_BIT_CNT_W-1:0] LAST_BIT = SPI_BIT_CNT_W'(SPI_BITS - 1);

  spi_state_e                 r_state;
  logic                       r_cpol;
  logic                       r_cpha;
  logic [SPI_BITS-1:0]        r_tx;
  logic [SPI_BITS-1:0]        r_rx;
  logic [SPI_BIT_CNT_W-1:0]   r_bit_cnt;
  logic                       r_mosi;
  logic                       r_ss;
  logic                       r_busy;
  logic                       r_done;
  logic [SPI_BITS-1:0]        r_data_out;

  spi_state_e                 w_state_nxt;
  logic                       w_cpol_nxt;
  logic                       w_cpha_nxt;
  logic [SPI_BITS-1:0]        w_tx_nxt;
  logic [SPI_BITS-1:0]        w_rx_nxt;
  logic [SPI_BIT_CNT_W-1:0]   w_bit_nxt;
  logic                       w_mosi_nxt;
  logic                       w_ss_nxt;
  logic                       w_busy_nxt;
  logic                       w_done_nxt;
  logic [SPI_BITS-1:0]        w_dout_nxt;

  logic                       w_run;
  logic                       w_gen_cpol;
  logic                       w_sclk;
  logic                       w_lead;
  logic                       w_trail;
  logic                       w_last;

  assign w_run      = (r_state == XFER) || (r_state == HOLD);
  // SETUP already uses the latched polarity so a late cpol change cannot glitch SCLK
  assign w_gen_cpol = ((r_state == IDLE) || (r_state == DONE)) ? cpol : r_cpol;

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk        (clk),
    .rst        (rst),
    .run        (w_run),
    .cpol       (w_gen_cpol),
    .sclk       (w_sclk),
    .lead_tick  (w_lead),
    .trail_tick (w_trail),
    .last_edge  (w_last)
  );

  // Next-state and next-datapath values for every register
  always_comb begin
    w_state_nxt = r_state;
    w_cpol_nxt  = r_cpol;
    w_cpha_nxt  = r_cpha;
    w_tx_nxt    = r_tx;
    w_rx_nxt    = r_rx;
    w_bit_nxt   = r_bit_cnt;
    w_mosi_nxt  = r_mosi;
    w_ss_nxt    = r_ss;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_dout_nxt  = r_data_out;
    case (r_state)
      IDLE, DONE: begin
        w_ss_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        if (start) begin
          w_cpol_nxt  = cpol;
          w_cpha_nxt  = cpha;
          w_tx_nxt    = data_in;
          w_state_nxt = SETUP;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SETUP: begin
        w_ss_nxt    = 1'b0;
        w_busy_nxt  = 1'b1;
        w_rx_nxt    = '0;
        w_bit_nxt   = '0;
        w_state_nxt = XFER;
        if (!r_cpha) begin
          w_mosi_nxt = r_tx[SPI_BITS-1];
        end else begin
          w_mosi_nxt = r_mosi;
        end
      end
      XFER: begin
        if (w_lead) begin
          if (!r_cpha) begin
            w_rx_nxt = shift_in(r_rx, miso);
          end else if (r_bit_cnt == '0) begin
            w_mosi_nxt = r_tx[SPI_BITS-1];
          end else begin
            w_tx_nxt   = shl1(r_tx);
            w_mosi_nxt = r_tx[SPI_BITS-2];
          end
        end else if (w_trail) begin
          w_bit_nxt = r_bit_cnt + SPI_BIT_CNT_W'(1);
          if (r_cpha) begin
            w_rx_nxt = shift_in(r_rx, miso);
          end else if (r_bit_cnt != LAST_BIT) begin
            w_tx_nxt   = shl1(r_tx);
            w_mosi_nxt = r_tx[SPI_BITS-2];
          end else begin
            w_mosi_nxt = r_mosi;
          end
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt = HOLD;
          end else begin
            w_state_nxt = XFER;
          end
        end else begin
          w_state_nxt = XFER;
        end
      end
      HOLD: begin
        if (w_last) begin
          w_state_nxt = DONE;
          w_ss_nxt    = 1'b1;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_dout_nxt  = r_rx;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_ss_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latched transfer settings, shift registers and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_bit_cnt  <= '0;
      r_mosi     <= 1'b0;
      r_ss       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_cpol     <= w_cpol_nxt;
      r_cpha     <= w_cpha_nxt;
      r_tx       <= w_tx_nxt;
      r_rx       <= w_rx_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_mosi     <= w_mosi_nxt;
      r_ss       <= w_ss_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_data_out <= w_dout_nxt;
    end
  end

  assign sclk     = w_sclk;
  assign mosi     = r_mosi;
  assign ss       = r_ss;
  assign busy     = r_busy;
  assign done     = r_done;
  assign data_out = r_data_out;

endmodule

// File: tb/tb_master_spi.sv
// Self-checking bench for master_spi: table of transfers against a behavioural
// SPI slave, plus hand sequences for back-to-back, mid-transfer reset and CLK_DIV=1.
module tb_master_spi;
  import spi_pkg::*;

  localparam int HALF = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpol, cpha, start;
  logic [7:0] data_in;
  wire        miso;
  logic       sclk, mosi, ss, busy, done;
  logic [7:0] data_out;

  logic       start1;
  logic [7:0] data_in1;
  logic       c1_zero;
  logic       sclk1, mosi1, ss1, busy1, done1;
  logic [7:0] data_out1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // slave model state
  logic       s_cpha = 1'b0;
  logic [7:0] s_byte = 8'h00;
  logic [7:0] s_rx   = 8'h00;
  int         s_edges = 0;
  logic       s_miso = 1'b0;
  logic       loop_en = 1'b0;

  assign miso = loop_en ? mosi : s_miso;

  master_spi #(.CLK_DIV(HALF)) u_dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .start(start),
    .data_in(data_in), .miso(miso), .sclk(sclk), .mosi(mosi), .ss(ss),
    .busy(busy), .done(done), .data_out(data_out)
  );

  master_spi #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .cpol(c1_zero), .cpha(c1_zero), .start(start1),
    .data_in(data_in1), .miso(c1_zero), .sclk(sclk1), .mosi(mosi1), .ss(ss1),
    .busy(busy1), .done(done1), .data_out(data_out1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural SPI slave: counts SCLK edges while selected, samples and drives by mode
  initial begin : slave
    logic prev_sclk, prev_ss, lead;
    int   j;
    prev_sclk = 1'b0;
    prev_ss   = 1'b1;
    forever begin
      @(sclk or ss);
      if (prev_ss && !ss) begin
        s_edges = 0;
        s_rx    = 8'h00;
        if (!s_cpha) s_miso = s_byte[7];
      end else if (!ss && (sclk !== prev_sclk)) begin
        s_edges++;
        j    = (s_edges - 1) / 2;
        lead = (s_edges % 2) == 1;
        if (lead ^ s_cpha) s_rx = {s_rx[6:0], mosi};
        else if (s_cpha) s_miso = s_byte[7-j];
        else if (j < 7) s_miso = s_byte[6-j];
      end
      prev_sclk = sclk;
      prev_ss   = ss;
    end
  end

  task automatic run_xfer(input logic p_cpol, input logic p_cpha, input logic [7:0] p_din,
                          input logic [7:0] p_sbyte, input logic p_loop,
                          input logic [7:0] exp_dout, input logic p_scramble);
    int   t0, d, ss_low;
    logic got_done;
    @(negedge clk);
    cpol = p_cpol; cpha = p_cpha; data_in = p_din;
    s_cpha = p_cpha; s_byte = p_sbyte; loop_en = p_loop; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    t0 = cyc;
    start = 1'b0;
    check("busy_accept_cycle", busy, 1'b0);
    if (p_scramble) begin
      cpol = 1'($urandom); cpha = 1'($urandom); data_in = 8'($urandom);
    end
    ss_low = 0;
    got_done = 1'b0;
    for (int i = 0; i < 200 && !got_done; i++) begin
      @(negedge clk);
      if (cyc == t0 + 1) begin
        check("ss_low_setup", ss, 1'b0);
        check("busy_setup", busy, 1'b1);
      end
      if (done) got_done = 1'b1;
      else if (!ss) ss_low++;
    end
    d = cyc;
    check("done_seen", got_done, 1'b1);
    check("done_latency", d - t0, 1 + 17 * HALF);
    check("ss_low_cycles", ss_low, 17 * HALF);
    check("data_out", data_out, exp_dout);
    check("slave_rx", s_rx, p_din);
    check("sclk_edges", s_edges, 16);
    check("sclk_at_done", sclk, p_cpol);
    check("ss_at_done", ss, 1'b1);
    check("busy_at_done", busy, 1'b0);
    cpol = p_cpol; cpha = p_cpha; data_in = p_din;
    @(negedge clk);
    check("done_one_clk", done, 1'b0);
    check("sclk_idle", sclk, p_cpol);
  endtask

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic       loopb;
    logic [7:0] din;
    logic [7:0] sbyte;
    logic [7:0] exp_dout;
    logic       scramble;
  } vec_t;

  vec_t vt[12];

  initial begin
    int   t0, d, ndone, toggles;
    logic got, prev;

    rst = 1'b0; cpol = 1'b0; cpha = 1'b0; start = 1'b0; data_in = 8'h00;
    start1 = 1'b0; data_in1 = 8'h00; c1_zero = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_ss", ss, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_data_out", data_out, 8'h00);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    vt[0] = '{SPI_MODE0[1], SPI_MODE0[0], 1'b1, 8'hA5, 8'h00, 8'hA5, 1'b0};
    vt[1] = '{SPI_MODE3[1], SPI_MODE3[0], 1'b0, 8'hC3, 8'h3C, 8'h3C, 1'b0};
    vt[2] = '{SPI_MODE1[1], SPI_MODE1[0], 1'b0, 8'h81, 8'h7E, 8'h7E, 1'b0};
    vt[3] = '{SPI_MODE2[1], SPI_MODE2[0], 1'b0, 8'h7E, 8'h81, 8'h81, 1'b0};
    for (int i = 4; i < 12; i++) begin
      vt[i].cpol     = 1'($urandom);
      vt[i].cpha     = 1'($urandom);
      vt[i].loopb    = 1'($urandom_range(0, 3) == 0);
      vt[i].din      = 8'($urandom);
      vt[i].sbyte    = 8'($urandom);
      vt[i].exp_dout = vt[i].loopb ? vt[i].din : vt[i].sbyte;
      vt[i].scramble = 1'b1;
    end
    for (int i = 0; i < 12; i++)
      run_xfer(vt[i].cpol, vt[i].cpha, vt[i].din, vt[i].sbyte, vt[i].loopb,
               vt[i].exp_dout, vt[i].scramble);

    // start held high through a transfer and its done cycle
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; data_in = 8'h5A; s_cpha = 1'b0; s_byte = 8'h96;
    loop_en = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    t0 = cyc;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    d = cyc;
    check("b2b_first_latency", d - t0, 1 + 17 * HALF);
    check("b2b_first_data", data_out, 8'h96);
    data_in = 8'h3D; s_byte = 8'hE1;
    @(negedge clk);
    check("b2b_done_plus1_ss", ss, 1'b1);
    check("b2b_done_plus1_done", done, 1'b0);
    @(negedge clk);
    check("b2b_second_ss", ss, 1'b0);
    check("b2b_second_busy", busy, 1'b1);
    start = 1'b0;
    got = 1'b0;
    ndone = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check("b2b_second_latency", cyc - (d + 1), 1 + 17 * HALF);
    check("b2b_second_data", data_out, 8'hE1);
    check("b2b_second_slave", s_rx, 8'h3D);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("b2b_no_extra_done", ndone, 0);
    check("b2b_idle_ss", ss, 1'b1);

    // reset asserted right after sclk edge 7
    @(negedge clk);
    data_in = 8'h33; s_byte = 8'hCC; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      #1;
      if (s_edges == 7 && !ss) got = 1'b1;
    end
    check("rst_edge7_reached", got, 1'b1);
    rst = 1'b0;
    #1;
    check("midrst_ss", ss, 1'b1);
    check("midrst_sclk", sclk, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_data_out", data_out, 8'h00);
    check("midrst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    check("midrst_data_kept", data_out, 8'h00);

    // CLK_DIV = 1 instance
    @(negedge clk);
    data_in1 = 8'hFF; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    t0 = cyc;
    start1 = 1'b0;
    prev = sclk1;
    toggles = 0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (sclk1 !== prev) toggles++;
      prev = sclk1;
      if (cyc == t0 + 1) check("div1_sclk_t1", sclk1, 1'b0);
      if (cyc == t0 + 2) check("div1_sclk_t2", sclk1, 1'b1);
      if (cyc == t0 + 3) check("div1_sclk_t3", sclk1, 1'b0);
      if (done1) got = 1'b1;
    end
    check("div1_done_seen", got, 1'b1);
    check("div1_latency", cyc - t0, 18);
    check("div1_toggles", toggles, 16);
    check("div1_data_out", data_out1, 8'h00);
    check("div1_mosi_last", mosi1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
